// File: rtl/interboard_pkg.sv
// Shared definitions for the inter-board move protocol (used by transmitter and receiver).
// Contents: message type codes, frame geometry, frame field layout, receiver FSM states.
package interboard_pkg;

   localparam int unsigned CHUNKS  = 4;
   localparam int unsigned CHUNK_W = 6;
   localparam int unsigned FRAME_W = CHUNKS * CHUNK_W;

   // Message types, game_top numbering
   localparam logic [3:0] TABLE_TAKE  = 4'd0;
   localparam logic [3:0] DECK_DRAW   = 4'd6;
   localparam logic [3:0] STATE_TURN  = 4'd7;
   localparam logic [3:0] STATE_CHEAT = 4'd8;
   localparam logic [3:0] MSG_MAX     = STATE_CHEAT;

   // Field offsets / widths inside the 24-bit frame
   localparam int unsigned MSG_LSB  = 20;
   localparam int unsigned MSG_W    = 4;
   localparam int unsigned X_LSB    = 15;
   localparam int unsigned X_W      = 5;
   localparam int unsigned Y_LSB    = 12;
   localparam int unsigned Y_W      = 3;
   localparam int unsigned CARD_LSB = 6;
   localparam int unsigned CARD_W   = 6;
   localparam int unsigned LEN_LSB  = 3;
   localparam int unsigned LEN_W    = 3;
   localparam int unsigned DIR_BIT  = 2;
   localparam int unsigned RES_W    = 2;

   // Packed view of a frame; chunk0 lands in the MSBs
   typedef struct packed {
      logic [MSG_W-1:0]  msg_type;
      logic [X_W-1:0]    block_x;
      logic [Y_W-1:0]    block_y;
      logic [CARD_W-1:0] card;
      logic [LEN_W-1:0]  sel_len;
      logic              move_dir;
      logic [RES_W-1:0]  reserved;
   } frame_t;

   typedef enum logic [1:0] {
      StWaitReq,
      StWaitRel,
      StCheck
   } rx_state_e;

endpackage

// File: rtl/interboard_rx_decoder_if.sv
// Inter-board chunk handshake bundle.
//  interboard_req : peer request (asynchronous to the receiver clock)
//  interboard_dat : chunk data, stable while req is high
//  interboard_ack : receiver acknowledge
// master = peer/transmitter side, slave = receiver side.
interface interboard_rx_decoder_if;
   import interboard_pkg::*;

   logic               interboard_req;
   logic [CHUNK_W-1:0] interboard_dat;
   logic               interboard_ack;

   modport master (
      output interboard_req,
      output interboard_dat,
      input  interboard_ack
   );

   modport slave (
      input  interboard_req,
      input  interboard_dat,
      output interboard_ack
   );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit.
//  clk   : destination clock
//  rst   : asynchronous active-high reset, clears both flops
//  d_i   : asynchronous input
//  q_o   : synchronised output
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/interboard_rx_decoder.sv
// Receiver of the inter-board move protocol. Collects four 6-bit chunks over a 4-phase
// req/ack handshake, validates the 24-bit frame and presents the decoded move.
//  clk, rst        : system clock, asynchronous active-high reset
//  bus (slave)     : interboard_req / interboard_dat in, interboard_ack out
//  rx_en           : one-cycle strobe, valid frame decoded (rx_* fields updated)
//  rx_err          : one-cycle strobe, frame dropped (invalid or timed out)
//  rx_msg_type .. rx_move_dir : decoded fields, held until the next valid frame
module interboard_rx_decoder
   import interboard_pkg::*;
#(
   parameter int unsigned TIMEOUT  = 1_000_000,
   parameter int unsigned MAX_CARD = 53,
   parameter int unsigned MAX_COL  = 17
) (
   input  logic                   clk,
   input  logic                   rst,
   interboard_rx_decoder_if.slave bus,
   output logic                   rx_en,
   output logic [MSG_W-1:0]       rx_msg_type,
   output logic [X_W-1:0]         rx_block_x,
   output logic [Y_W-1:0]         rx_block_y,
   output logic [CARD_W-1:0]      rx_card,
   output logic [LEN_W-1:0]       rx_sel_len,
   output logic                   rx_move_dir,
   output logic                   rx_err
);

   localparam int unsigned TimerW = $clog2(TIMEOUT + 1);
   localparam logic [1:0]  LastChunk = 2'(CHUNKS - 1);

   // ---------------------------------------------------------------- req synchroniser
   logic req_sync;
   logic req_prev_q;
   logic req_s_q;
   logic req_s;

   sync_2ff u_sync_req (
      .clk (clk),
      .rst (rst),
      .d_i (bus.interboard_req),
      .q_o (req_sync)
   );

   // req_s only follows the synchroniser once two consecutive samples agree, so a req pulse
   // seen for a single cycle never reaches the FSM.
   always_comb begin
      req_s = req_s_q;
      if (req_sync == req_prev_q) begin
         req_s = req_sync;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_prev_q <= 1'b0;
         req_s_q    <= 1'b0;
      end else begin
         req_prev_q <= req_sync;
         req_s_q    <= req_s;
      end
   end

   // ---------------------------------------------------------------- FSM + datapath
   rx_state_e          state_q, state_d;
   logic [1:0]         chunk_cnt_q, chunk_cnt_d;
   logic [FRAME_W-1:0] sh_q, sh_d;
   logic               ack_q, ack_d;
   logic [TimerW-1:0]  timer_q, timer_d;
   logic               counting;
   logic               timeout;

   assign counting = (chunk_cnt_q != 2'd0) || (state_q == StWaitRel);
   assign timeout  = counting && (timer_q == TimerW'(TIMEOUT - 1));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StWaitReq;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic, including handshake datapath and timer
   always_comb begin
      state_d     = state_q;
      chunk_cnt_d = chunk_cnt_q;
      sh_d        = sh_q;
      ack_d       = ack_q;
      if (timeout) begin
         state_d     = StWaitReq;
         ack_d       = 1'b0;
         chunk_cnt_d = 2'd0;
      end else begin
         unique case (state_q)
            StWaitReq: begin
               if (req_s) begin
                  sh_d    = {sh_q[FRAME_W-CHUNK_W-1:0], bus.interboard_dat};
                  ack_d   = 1'b1;
                  state_d = StWaitRel;
               end
            end
            StWaitRel: begin
               if (!req_s) begin
                  ack_d = 1'b0;
                  if (chunk_cnt_q == LastChunk) begin
                     state_d = StCheck;
                  end else begin
                     chunk_cnt_d = chunk_cnt_q + 2'd1;
                     state_d     = StWaitReq;
                  end
               end
            end
            StCheck: begin
               chunk_cnt_d = 2'd0;
               state_d     = StWaitReq;
            end
            default: begin
               state_d = StWaitReq;
            end
         endcase
      end
      // Any transition (and the timeout itself) restarts the progress timer
      if (timeout || (state_d != state_q) || !counting) begin
         timer_d = '0;
      end else begin
         timer_d = timer_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chunk_cnt_q <= 2'd0;
         sh_q        <= '0;
         ack_q       <= 1'b0;
         timer_q     <= '0;
      end else begin
         chunk_cnt_q <= chunk_cnt_d;
         sh_q        <= sh_d;
         ack_q       <= ack_d;
         timer_q     <= timer_d;
      end
   end

   assign bus.interboard_ack = ack_q;

   // ---------------------------------------------------------------- output logic
   frame_t frame;
   logic   frame_ok;
   logic   load_fields;
   logic   err_d;

   always_comb begin
      frame       = frame_t'(sh_q);
      frame_ok    = (frame.msg_type <= MSG_MAX)
                 && (32'(frame.block_x) <= MAX_COL)
                 && (32'(frame.card) <= MAX_CARD)
                 && (frame.reserved == '0);
      load_fields = (state_q == StCheck) && frame_ok && !timeout;
      err_d       = timeout || ((state_q == StCheck) && !frame_ok);
   end

   logic              rx_en_q;
   logic              rx_err_q;
   logic [MSG_W-1:0]  rx_msg_type_q;
   logic [X_W-1:0]    rx_block_x_q;
   logic [Y_W-1:0]    rx_block_y_q;
   logic [CARD_W-1:0] rx_card_q;
   logic [LEN_W-1:0]  rx_sel_len_q;
   logic              rx_move_dir_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_en_q       <= 1'b0;
         rx_err_q      <= 1'b0;
         rx_msg_type_q <= '0;
         rx_block_x_q  <= '0;
         rx_block_y_q  <= '0;
         rx_card_q     <= '0;
         rx_sel_len_q  <= '0;
         rx_move_dir_q <= 1'b0;
      end else begin
         rx_en_q  <= load_fields;
         rx_err_q <= err_d;
         if (load_fields) begin
            rx_msg_type_q <= frame.msg_type;
            rx_block_x_q  <= frame.block_x;
            rx_block_y_q  <= frame.block_y;
            rx_card_q     <= frame.card;
            rx_sel_len_q  <= frame.sel_len;
            rx_move_dir_q <= frame.move_dir;
         end
      end
   end

   assign rx_en       = rx_en_q;
   assign rx_err      = rx_err_q;
   assign rx_msg_type = rx_msg_type_q;
   assign rx_block_x  = rx_block_x_q;
   assign rx_block_y  = rx_block_y_q;
   assign rx_card     = rx_card_q;
   assign rx_sel_len  = rx_sel_len_q;
   assign rx_move_dir = rx_move_dir_q;

endmodule

// File: tb/tb_interboard_rx_decoder.sv
// Testbench for interboard_rx_decoder: directed protocol scenarios plus randomized frames
// checked against a field-level reference model.
module tb_interboard_rx_decoder;
   import interboard_pkg::*;

   localparam int unsigned TO   = 100;
   localparam int unsigned MAXC = 53;
   localparam int unsigned MAXX = 17;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   interboard_rx_decoder_if bus ();

   logic        rx_en, rx_err, rx_move_dir;
   logic [3:0]  rx_msg_type;
   logic [4:0]  rx_block_x;
   logic [2:0]  rx_block_y;
   logic [5:0]  rx_card;
   logic [2:0]  rx_sel_len;

   interboard_rx_decoder #(
      .TIMEOUT  (TO),
      .MAX_CARD (MAXC),
      .MAX_COL  (MAXX)
   ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .rx_en       (rx_en),
      .rx_msg_type (rx_msg_type),
      .rx_block_x  (rx_block_x),
      .rx_block_y  (rx_block_y),
      .rx_card     (rx_card),
      .rx_sel_len  (rx_sel_len),
      .rx_move_dir (rx_move_dir),
      .rx_err      (rx_err)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // Monitor, sampled 1 time unit after each rising edge
   int     cyc      = 0;
   int     en_cnt   = 0;
   int     err_cnt  = 0;
   int     both_cnt = 0;
   int     ack_tog  = 0;
   logic   ack_prev = 1'b0;
   frame_t cap_q[$];

   function automatic frame_t dut_fields();
      return frame_t'({rx_msg_type, rx_block_x, rx_block_y, rx_card, rx_sel_len,
                       rx_move_dir, 2'b00});
   endfunction

   always @(posedge clk) begin
      #1;
      cyc <= cyc + 1;
      if (rx_en) begin
         en_cnt <= en_cnt + 1;
         cap_q.push_back(dut_fields());
      end
      if (rx_err) err_cnt <= err_cnt + 1;
      if (rx_en && rx_err) both_cnt <= both_cnt + 1;
      if (bus.interboard_ack !== ack_prev) ack_tog <= ack_tog + 1;
      ack_prev <= bus.interboard_ack;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: legality rules applied to the frame fields
   function automatic bit is_valid(input frame_t f);
      return (f.msg_type <= 4'd8) && (int'(f.block_x) <= int'(MAXX))
          && (int'(f.card) <= int'(MAXC)) && (f.reserved == 2'b00);
   endfunction

   function automatic frame_t mk(input int m, input int x, input int y, input int c,
                                 input int l, input int d, input int r);
      frame_t f;
      f.msg_type = 4'(m);
      f.block_x  = 5'(x);
      f.block_y  = 3'(y);
      f.card     = 6'(c);
      f.sel_len  = 3'(l);
      f.move_dir = 1'(d);
      f.reserved = 2'(r);
      return f;
   endfunction

   task automatic wait_ack(input logic v, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.interboard_ack === v) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic send_chunk(input logic [5:0] d, input int gap);
      bit ok;
      repeat (gap) @(negedge clk);
      bus.interboard_dat = d;
      bus.interboard_req = 1'b1;
      wait_ack(1'b1, ok);
      if (!ok) check("ack_rise_wait", 32'(ok), 32'd1);
      bus.interboard_req = 1'b0;
      wait_ack(1'b0, ok);
      if (!ok) check("ack_fall_wait", 32'(ok), 32'd1);
   endtask

   task automatic send_frame(input frame_t f, input int gap);
      logic [23:0] fv;
      fv = f;
      for (int c = 0; c < 4; c++) send_chunk(fv[(23 - 6 * c) -: 6], gap);
   endtask

   frame_t exp_fields = '0;

   // Send one frame and compare strobes and held fields against the model
   task automatic frame_and_check(input string tag, input frame_t f, input int gap);
      int  e0, r0;
      bit  v;
      e0 = en_cnt;
      r0 = err_cnt;
      send_frame(f, gap);
      repeat (4) @(negedge clk);
      v = is_valid(f);
      if (v) exp_fields = f;
      check({tag, "_rx_en"}, 32'(en_cnt - e0), 32'(v));
      check({tag, "_rx_err"}, 32'(err_cnt - r0), 32'(!v));
      check({tag, "_fields"}, 32'(dut_fields()), 32'(exp_fields));
   endtask

   function automatic frame_t rand_frame();
      int mode;
      mode = int'($urandom_range(0, 3));
      if (mode == 0) begin
         return mk(int'($urandom_range(0, 15)), int'($urandom_range(0, 31)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 63)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)));
      end
      return mk(int'($urandom_range(0, 8)), int'($urandom_range(0, MAXX)),
                int'($urandom_range(0, 7)), int'($urandom_range(0, MAXC)),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), 0);
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int     t0, e0, r0, diff, ackt0;
      bit     seen;
      frame_t f1, fa, fb;

      rst = 1'b1;
      bus.interboard_req = 1'b0;
      bus.interboard_dat = '0;
      repeat (3) @(negedge clk);
      check("reset_state", {rx_en, rx_err, bus.interboard_ack, 21'(dut_fields() >> 2)}, 32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Test 1: basic valid frame, 4 ack pulses
      f1 = mk(2, 16, 3, 21, 1, 0, 0);
      ackt0 = ack_tog;
      frame_and_check("t1", f1, 2);
      check("t1_ack_toggles", 32'(ack_tog - ackt0), 32'd8);
      check("t1_msg", 32'(rx_msg_type), 32'd2);
      check("t1_x", 32'(rx_block_x), 32'd16);
      check("t1_card", 32'(rx_card), 32'd21);

      // Test 2: illegal msg_type
      frame_and_check("t2", mk(12, 3, 1, 5, 2, 1, 0), 1);
      // Boundary legality
      frame_and_check("bnd_max", mk(8, MAXX, 7, MAXC, 7, 1, 0), 1);
      frame_and_check("bnd_col", mk(1, MAXX + 1, 0, 0, 0, 0, 0), 1);
      frame_and_check("bnd_card", mk(1, 0, 0, MAXC + 1, 0, 0, 0), 1);
      frame_and_check("bnd_res", mk(1, 0, 0, 0, 0, 0, 2), 1);
      frame_and_check("bnd_msg9", mk(9, 0, 0, 0, 0, 0, 0), 1);

      // Test 3: partial frame times out TO cycles after the last transition
      e0 = en_cnt;
      r0 = err_cnt;
      send_chunk(6'h15, 1);
      send_chunk(6'h2A, 1);
      t0 = cyc;
      seen = 1'b0;
      diff = 0;
      for (int i = 0; i < 3 * int'(TO); i++) begin
         @(negedge clk);
         if (rx_err) begin
            seen = 1'b1;
            diff = cyc - t0;
            break;
         end
      end
      check("t3_err_seen", 32'(seen), 32'd1);
      check("t3_err_delay", 32'(diff), 32'(TO));
      repeat (3) @(negedge clk);
      check("t3_err_count", 32'(err_cnt - r0), 32'd1);
      check("t3_no_en", 32'(en_cnt - e0), 32'd0);
      check("t3_ack", 32'(bus.interboard_ack), 32'd0);
      check("t3_fields_held", 32'(dut_fields()), 32'(exp_fields));
      frame_and_check("t3_after", mk(5, 7, 2, 40, 3, 1, 0), 1);

      // Test 4: reset while waiting for release of the third chunk
      send_chunk(6'h01, 1);
      send_chunk(6'h02, 1);
      bus.interboard_dat = 6'h03;
      bus.interboard_req = 1'b1;
      wait_ack(1'b1, seen);
      check("t4_in_wait_rel", 32'(seen), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("t4_reset_outputs", {rx_en, rx_err, bus.interboard_ack, 21'(dut_fields() >> 2)},
            32'd0);
      exp_fields = '0;
      bus.interboard_req = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      frame_and_check("t4_after", mk(3, 11, 5, 33, 6, 0, 0), 1);

      // Test 5: back-to-back frames, no gaps
      fa = mk(7, 1, 4, 9, 2, 1, 0);
      fb = mk(0, 17, 6, 52, 5, 0, 0);
      e0 = en_cnt;
      r0 = err_cnt;
      cap_q.delete();
      send_frame(fa, 0);
      send_frame(fb, 0);
      repeat (4) @(negedge clk);
      check("t5_en_count", 32'(en_cnt - e0), 32'd2);
      check("t5_err_count", 32'(err_cnt - r0), 32'd0);
      if (cap_q.size() == 2) begin
         check("t5_frame_a", 32'(cap_q[0]), 32'(fa));
         check("t5_frame_b", 32'(cap_q[1]), 32'(fb));
      end else begin
         check("t5_cap_size", 32'(cap_q.size()), 32'd2);
      end
      exp_fields = fb;

      // Test 6: single-cycle req glitch is ignored
      ackt0 = ack_tog;
      e0 = en_cnt;
      r0 = err_cnt;
      bus.interboard_dat = 6'h3F;
      bus.interboard_req = 1'b1;
      @(negedge clk);
      bus.interboard_req = 1'b0;
      repeat (12) @(negedge clk);
      check("t6_no_ack", 32'(ack_tog - ackt0), 32'd0);
      check("t6_no_strobe", 32'((en_cnt - e0) + (err_cnt - r0)), 32'd0);
      frame_and_check("t6_after", mk(4, 9, 1, 17, 4, 1, 0), 1);

      // Randomized frames against the model
      for (int n = 0; n < 24; n++) begin
         frame_and_check($sformatf("rnd%0d", n), rand_frame(), int'($urandom_range(0, 3)));
      end

      check("never_both_strobes", 32'(both_cnt), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
